// File: rtl/uart_echo_seq.sv
// Frame echo sequencer: reads bytes from a UART I/O stage until TERM or DEPTH
// bytes have arrived, writes them back in order, then writes their XOR checksum.
// Latency: one cycle per FSM step; outputs are registered.
// Backpressure: every request is a four-phase handshake on uart_done, so the UART stage paces the block.
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   start                 one-cycle frame request, honoured only in IDLE
//   uart_oen / uart_wen   active-low read / write requests to the UART stage
//   uart_tx_data          byte presented for a write
//   uart_rx_data          byte returned by a read
//   uart_done             UART stage completion flag (raise, then release)
//   busy, frame_done      sequence active; one-cycle completion pulse
//   frame_len, checksum   byte count and XOR of the last completed frame
module uart_echo_seq #(
  parameter int         DEPTH = 8,
  parameter logic [7:0] TERM  = 8'h0A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       uart_oen,
  output logic       uart_wen,
  output logic [7:0] uart_tx_data,
  input  logic [7:0] uart_rx_data,
  input  logic       uart_done,
  output logic       busy,
  output logic       frame_done,
  output logic [4:0] frame_len,
  output logic [7:0] checksum
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_REL, WR_REQ, WR_REL, CK_REQ, CK_REL
  } state_t;

  state_t      state_q, state_d;
  logic        oen_q, oen_d;
  logic        wen_q, wen_d;
  logic [7:0]  tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        fdone_q, fdone_d;
  logic [4:0]  flen_q, flen_d;
  logic [7:0]  cks_q, cks_d;
  // Running XOR of the frame in progress; cks_q only updates at frame end.
  logic [7:0]  acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  idx_q, idx_d;
  // Most recently captured byte, used for the terminator test in RD_REL.
  logic [7:0]  last_q, last_d;

  logic [7:0]  mem_q [2**AW];
  logic        mem_we;
  logic [4:0]  idx_nx;

  assign idx_nx = idx_q + 5'd1;

  always_comb begin
    state_d = state_q;
    oen_d   = oen_q;
    wen_d   = wen_q;
    tx_d    = tx_q;
    fdone_d = 1'b0;
    flen_d  = flen_q;
    cks_d   = cks_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    mem_we  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = '0;
          acc_d   = '0;
          oen_d   = 1'b0;
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        if (uart_done) begin
          mem_we  = 1'b1;
          acc_d   = acc_q ^ uart_rx_data;
          last_d  = uart_rx_data;
          cnt_d   = cnt_q + 5'd1;
          oen_d   = 1'b1;
          state_d = RD_REL;
        end
      end
      RD_REL: begin
        // Only reissue after the stage has released uart_done.
        if (!uart_done) begin
          if (last_q == TERM || cnt_q == 5'(DEPTH)) begin
            idx_d   = '0;
            tx_d    = mem_q[{AW{1'b0}}];
            wen_d   = 1'b0;
            state_d = WR_REQ;
          end else begin
            oen_d   = 1'b0;
            state_d = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        if (uart_done) begin
          wen_d   = 1'b1;
          state_d = WR_REL;
        end
      end
      WR_REL: begin
        if (!uart_done) begin
          if (idx_nx < cnt_q) begin
            idx_d   = idx_nx;
            tx_d    = mem_q[idx_nx[AW-1:0]];
            state_d = WR_REQ;
          end else begin
            tx_d    = acc_q;
            state_d = CK_REQ;
          end
          wen_d = 1'b0;
        end
      end
      CK_REQ: begin
        if (uart_done) begin
          wen_d   = 1'b1;
          state_d = CK_REL;
        end
      end
      CK_REL: begin
        if (!uart_done) begin
          fdone_d = 1'b1;
          flen_d  = cnt_q;
          cks_d   = acc_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      oen_q   <= 1'b1;
      wen_q   <= 1'b1;
      tx_q    <= '0;
      busy_q  <= 1'b0;
      fdone_q <= 1'b0;
      flen_q  <= '0;
      cks_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      oen_q   <= oen_d;
      wen_q   <= wen_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      fdone_q <= fdone_d;
      flen_q  <= flen_d;
      cks_q   <= cks_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  // Byte buffer has no reset; entries are always written before being read.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[cnt_q[AW-1:0]] <= uart_rx_data;
    end
  end

  assign uart_oen     = oen_q;
  assign uart_wen     = wen_q;
  assign uart_tx_data = tx_q;
  assign busy         = busy_q;
  assign frame_done   = fdone_q;
  assign frame_len    = flen_q;
  assign checksum     = cks_q;

endmodule

// File: tb/tb_uart_echo_seq.sv
module tb_uart_echo_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       uart_oen;
  logic       uart_wen;
  logic [7:0] uart_tx_data;
  logic [7:0] uart_rx_data;
  logic       uart_done;
  logic       busy;
  logic       frame_done;
  logic [4:0] frame_len;
  logic [7:0] checksum;

  always #5 clk = ~clk;

  uart_echo_seq #(.DEPTH(8), .TERM(8'h0A)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .uart_oen     (uart_oen),
    .uart_wen     (uart_wen),
    .uart_tx_data (uart_tx_data),
    .uart_rx_data (uart_rx_data),
    .uart_done    (uart_done),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_len    (frame_len),
    .checksum     (checksum)
  );

  int         n_assert = 0;
  int         n_fail   = 0;
  int         hold     = 1;
  bit         wr_ack_en = 1'b1;
  int         fd_cnt   = 0;
  int         rd_cnt   = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [4:0] exp_len;
  logic [7:0] exp_cks;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycle-by-cycle exclusivity of the two requests, plus frame_done pulse count.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("oen_wen_exclusive", 32'(uart_oen | uart_wen), 32'd1);
      if (frame_done === 1'b1) fd_cnt++;
    end
  end

  // UART stage model: answers reads from rx_q, scores writes against exp_q.
  initial begin
    uart_done    = 1'b0;
    uart_rx_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && uart_oen === 1'b0) begin
        @(negedge clk);
        if (rx_q.size() > 0) begin
          uart_rx_data = rx_q.pop_front();
        end else begin
          n_assert++;
          n_fail++;
          $error("FAIL rx_underflow: observed read request, expected none");
        end
        rd_cnt++;
        uart_done = 1'b1;
        repeat (hold) @(negedge clk);
        uart_done = 1'b0;
      end else if (rst === 1'b0 && uart_wen === 1'b0 && wr_ack_en) begin
        @(negedge clk);
        if (exp_q.size() > 0) begin
          check("tx_byte", 32'(uart_tx_data), 32'(exp_q.pop_front()));
        end else begin
          n_assert++;
          n_fail++;
          $error("FAIL tx_extra: observed write %0h, expected none", uart_tx_data);
        end
        uart_done = 1'b1;
        repeat (hold) @(negedge clk);
        uart_done = 1'b0;
      end
    end
  end

  // Reference model: queue the read bytes and the echo the block must produce.
  task automatic push_frame(input logic [7:0] b[$]);
    logic [7:0] x;
    int         n;
    x = 8'h00;
    n = 0;
    foreach (b[i]) begin
      rx_q.push_back(b[i]);
      exp_q.push_back(b[i]);
      x = x ^ b[i];
      n++;
      if (b[i] == 8'h0A || n == 8) break;
    end
    exp_q.push_back(x);
    exp_len = 5'(n);
    exp_cks = x;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_frame(input string tag, input int fd0);
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (frame_done === 1'b1) break;
    end
    check({tag, "_done_seen"}, 32'(frame_done), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_frame_len"}, 32'(frame_len), 32'(exp_len));
    check({tag, "_checksum"}, 32'(checksum), 32'(exp_cks));
    repeat (4) @(negedge clk);
    check({tag, "_done_pulses"}, 32'(fd_cnt - fd0), 32'd1);
    check({tag, "_done_low"}, 32'(frame_done), 32'd0);
    check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_reads_left"}, 32'(rx_q.size()), 32'd0);
    check({tag, "_len_held"}, 32'(frame_len), 32'(exp_len));
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b[$]);
    int fd0;
    fd0 = fd_cnt;
    push_frame(b);
    do_start();
    finish_frame(tag, fd0);
  endtask

  initial begin
    logic [7:0] b[$];
    int         r0;
    int         fd0;
    int         k;

    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_oen", 32'(uart_oen), 32'd1);
    check("rst_wen", 32'(uart_wen), 32'd1);
    check("rst_tx", 32'(uart_tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_len", 32'(frame_len), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Terminated frame: 41 42 0A -> echo plus checksum 09.
    b = {8'h41, 8'h42, 8'h0A};
    run_frame("term3", b);
    check("term3_cks_const", 32'(checksum), 32'h09);

    // Full buffer without terminator: stops reading after 8 bytes.
    b = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    r0 = rd_cnt;
    run_frame("full8", b);
    check("full8_reads", 32'(rd_cnt - r0), 32'd8);
    check("full8_len_const", 32'(frame_len), 32'd8);

    // Single terminator byte.
    b = {8'h0A};
    run_frame("single", b);
    check("single_len_const", 32'(frame_len), 32'd1);

    // start pulsed mid-frame must be ignored.
    b = {8'h11, 8'h22, 8'h0A};
    fd0 = fd_cnt;
    push_frame(b);
    do_start();
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_frame("busy_start", fd0);
    repeat (10) @(negedge clk);
    check("busy_start_no_restart", 32'(busy), 32'd0);

    // Long uart_done assertion: one capture/advance per handshake.
    hold = 5;
    b = {8'h55, 8'hAA, 8'h3C, 8'h0A};
    run_frame("hold5_term", b);
    b = {8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    run_frame("hold5_full", b);
    hold = 1;

    // Reset while a write request is outstanding.
    wr_ack_en = 1'b0;
    b = {8'h41, 8'h42, 8'h0A};
    fd0 = fd_cnt;
    push_frame(b);
    do_start();
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (uart_wen === 1'b0) break;
    end
    check("abort_wr_req_reached", 32'(uart_wen), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("abort_wen", 32'(uart_wen), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_frame_done", 32'(frame_done), 32'd0);
    check("abort_frame_len", 32'(frame_len), 32'd0);
    check("abort_checksum", 32'(checksum), 32'd0);
    exp_q.delete();
    rx_q.delete();
    wr_ack_en = 1'b1;
    @(negedge clk);
    check("abort_no_pulse", 32'(fd_cnt - fd0), 32'd0);

    // Release reset and request a new frame in the very next cycle.
    b = {8'h41, 8'h42, 8'h0A};
    fd0 = fd_cnt;
    push_frame(b);
    rst   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("post_rst_busy", 32'(busy), 32'd1);
    finish_frame("post_rst", fd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
